// File: rtl/combo_lock_pkg.sv
// rtl/combo_lock_pkg.sv - shared state type and active-low 7-segment glyphs (bit 6 = g .. bit 0 = a)
package combo_lock_pkg;

  typedef enum logic [2:0] {ENTRY, CLOSED, OPEN, PROG, LOCKOUT} lock_state_t;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_O    = 7'h40;
  localparam logic [6:0] SEG_C    = 7'h46;
  localparam logic [6:0] SEG_E    = 7'h06;
  localparam logic [6:0] SEG_R    = 7'h2F;
  localparam logic [6:0] SEG_P    = 7'h0C;
  localparam logic [6:0] SEG_N    = 7'h2B;
  localparam logic [6:0] SEG_L    = 7'h47;
  localparam logic [6:0] SEG_S    = 7'h12;
  localparam logic [6:0] SEG_D    = 7'h21;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD digit to active-low 7-segment pattern; non-BCD codes blank
module seg7_decode
  import combo_lock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/combo_lock_param.sv
// rtl/combo_lock_param.sv - parametrised digit-sequence lock with reprogrammable code and failed-attempt lockout
module combo_lock_param
  import combo_lock_pkg::*;
#(
  parameter int          DIGITS         = 6,
  parameter logic [31:0] DEFAULT_CODE   = 32'h00722297,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       prog_req,
  input  logic       relock,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       is_open,
  output logic       locked_out,
  output logic [3:0] fails
);

  localparam int              CB        = 4 * DIGITS;
  localparam int              CW        = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [3:0]      LAST      = 4'(DIGITS - 1);
  localparam logic [3:0]      MAXF      = 4'(MAX_TRIES);
  localparam logic [CW-1:0]   LO_INIT   = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [CB-1:0]   CODE_INIT = DEFAULT_CODE[CB-1:0];

  lock_state_t   state;
  logic [3:0]    idx;
  logic          mismatch;
  logic [CB-1:0] code;
  logic [CB-1:0] shadow;
  logic [CW-1:0] lo_cnt;

  logic          legal;
  logic [3:0]    cmp_idx;
  logic [3:0]    cur_nib;
  logic          att_last;
  logic          att_bad;
  logic [3:0]    widx;
  logic          prog_last;
  logic [CB-1:0] shadow_next;
  logic [6:0]    digit_seg;

  // Digit 1 is the most significant used nibble, so index k maps to nibble DIGITS-1-k.
  function automatic logic [3:0] nib_at(input logic [CB-1:0] c, input logic [3:0] i);
    nib_at = 4'd0;
    for (int k = 0; k < DIGITS; k++)
      if (i == 4'(k)) nib_at = c[4*(DIGITS-1-k) +: 4];
  endfunction

  always_comb begin
    legal       = digit_valid && (digit <= 4'd9);
    cmp_idx     = (state == CLOSED) ? 4'd0 : idx;
    cur_nib     = nib_at(code, cmp_idx);
    att_last    = legal && ((state == ENTRY && idx == LAST) || (state == CLOSED && DIGITS == 1));
    att_bad     = (state == ENTRY && mismatch) || (digit != cur_nib);
    widx        = (state == OPEN) ? 4'd0 : idx;
    prog_last   = (widx == LAST);
    shadow_next = shadow;
    for (int k = 0; k < DIGITS; k++)
      if (widx == 4'(k)) shadow_next[4*(DIGITS-1-k) +: 4] = digit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ENTRY;
      idx        <= 4'd0;
      mismatch   <= 1'b0;
      fails      <= 4'd0;
      code       <= CODE_INIT;
      shadow     <= '0;
      lo_cnt     <= '0;
      is_open    <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      case (state)
        ENTRY, CLOSED: begin
          if (att_last) begin
            idx      <= 4'd0;
            mismatch <= 1'b0;
            if (!att_bad) begin
              state   <= OPEN;
              fails   <= 4'd0;
              is_open <= 1'b1;
            end else if (fails + 4'd1 == MAXF) begin
              state      <= LOCKOUT;
              lo_cnt     <= LO_INIT;
              fails      <= MAXF;
              locked_out <= 1'b1;
            end else begin
              state <= CLOSED;
              fails <= fails + 4'd1;
            end
          end else if (legal) begin
            // From CLOSED idx is 0, so this also starts a fresh attempt at idx=1.
            state    <= ENTRY;
            idx      <= idx + 4'd1;
            mismatch <= att_bad;
          end
        end
        OPEN: begin
          if (relock) begin
            state   <= ENTRY;
            is_open <= 1'b0;
          end else if (legal && prog_req) begin
            shadow <= shadow_next;
            if (prog_last) begin
              code    <= shadow_next;
              state   <= ENTRY;
              idx     <= 4'd0;
              is_open <= 1'b0;
            end else begin
              state <= PROG;
              idx   <= 4'd1;
            end
          end
        end
        PROG: begin
          if (relock) begin
            state   <= ENTRY;
            idx     <= 4'd0;
            is_open <= 1'b0;
          end else if (legal) begin
            shadow <= shadow_next;
            if (prog_last) begin
              code    <= shadow_next;
              state   <= ENTRY;
              idx     <= 4'd0;
              is_open <= 1'b0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        LOCKOUT: begin
          if (lo_cnt == '0) begin
            state      <= ENTRY;
            fails      <= 4'd0;
            locked_out <= 1'b0;
          end else begin
            lo_cnt <= lo_cnt - CW'(1);
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

  seg7_decode u_seg7 (
    .bcd (digit),
    .seg (digit_seg)
  );

  always_comb begin
    {hex5, hex4, hex3, hex2, hex1, hex0} = {6{SEG_OFF}};
    case (state)
      LOCKOUT: {hex5, hex4, hex3, hex2, hex1, hex0} = {6{SEG_DASH}};
      OPEN:    {hex3, hex2, hex1, hex0} = {SEG_O, SEG_P, SEG_E, SEG_N};
      CLOSED: begin
        if (digit > 4'd9) {hex4, hex3, hex2, hex1, hex0} = {SEG_E, SEG_R, SEG_R, SEG_O, SEG_R};
        else {hex5, hex4, hex3, hex2, hex1, hex0} = {SEG_C, SEG_L, SEG_O, SEG_S, SEG_E, SEG_D};
      end
      default: begin
        if (digit > 4'd9) {hex4, hex3, hex2, hex1, hex0} = {SEG_E, SEG_R, SEG_R, SEG_O, SEG_R};
        else hex0 = digit_seg;
        if (state == PROG) hex5 = SEG_P;
      end
    endcase
  end

endmodule

// File: tb/tb_combo_lock_param.sv
// tb/tb_combo_lock_param.sv - scoreboard bench for combo_lock_param (default build and a 4-digit build)
module tb_combo_lock_param;

  localparam logic [6:0] G_OFF = 7'h7F, G_O = 7'h40, G_P = 7'h0C, G_E = 7'h06, G_N = 7'h2B;
  localparam logic [6:0] G_R = 7'h2F, G_C = 7'h46, G_L = 7'h47, G_S = 7'h12, G_D = 7'h21;
  localparam logic [6:0] G_DASH = 7'h3F, G_1 = 7'h79, G_2 = 7'h24;

  logic clk = 1'b0;
  logic reset, dv, pr, rl, b_dv, b_pr, b_rl;
  logic [3:0] dg, b_dg;
  logic [6:0] h0, h1, h2, h3, h4, h5, bh0, bh1, bh2, bh3, bh4, bh5;
  logic is_open, locked_out, b_open, b_lo;
  logic [3:0] fails, b_fails;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] sb[$];
  logic [5:0] obs[$];
  logic [5:0] e, a;

  always #5 clk = ~clk;

  combo_lock_param dut (
    .clk(clk), .reset(reset), .digit_valid(dv), .digit(dg), .prog_req(pr), .relock(rl),
    .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3), .hex4(h4), .hex5(h5),
    .is_open(is_open), .locked_out(locked_out), .fails(fails)
  );

  combo_lock_param #(.DIGITS(4), .DEFAULT_CODE(32'h1234)) dut4 (
    .clk(clk), .reset(reset), .digit_valid(b_dv), .digit(b_dg), .prog_req(b_pr), .relock(b_rl),
    .hex0(bh0), .hex1(bh1), .hex2(bh2), .hex3(bh3), .hex4(bh4), .hex5(bh5),
    .is_open(b_open), .locked_out(b_lo), .fails(b_fails)
  );

  // All helpers start and end just after a falling edge.
  task automatic step(input bit sel, input logic v, input logic [3:0] d, input logic p);
    if (sel) begin b_dv = v; b_dg = d; b_pr = p; end
    else begin dv = v; dg = d; pr = p; end
    @(negedge clk);
    if (sel) begin b_dv = 1'b0; b_pr = 1'b0; end
    else begin dv = 1'b0; pr = 1'b0; end
  endtask

  task automatic enter(input bit sel, input logic [31:0] code, input int n,
                       input logic [5:0] mid, input logic [5:0] fin, input logic p);
    for (int i = 0; i < n; i++) begin
      sb.push_back((i == n - 1) ? fin : mid);
      step(sel, 1'b1, code[4*(n-1-i) +: 4], p);
      obs.push_back(sel ? {b_open, b_lo, b_fails} : {is_open, locked_out, fails});
    end
  endtask

  task automatic pulse_relock();
    rl = 1'b1;
    @(negedge clk);
    rl = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dv = 0; dg = 0; pr = 0; rl = 0;
    b_dv = 0; b_dg = 0; b_pr = 0; b_rl = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({is_open, locked_out, fails} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {is_open, locked_out, fails});
    end
    n_tests++;
    if ({h5, h4, h3, h2, h1, h0} !== {G_OFF, G_OFF, G_OFF, G_OFF, G_OFF, G_O}) begin
      n_fail++; $display("FAIL reset_hex: got %h want digit 0 on hex0", {h5, h4, h3, h2, h1, h0});
    end
    n_tests++;
    if ({b_open, b_lo, b_fails} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags4: got %b want 000000", {b_open, b_lo, b_fails});
    end
    reset = 1'b0;
  endtask

  task automatic test_open();
    enter(0, 32'h722297, 6, 6'b00_0000, 6'b10_0000, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a = obs.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL open_seq: got %b want %b", a, e); end
    end
    n_tests++;
    if ({h5, h4, h3, h2, h1, h0} !== {G_OFF, G_OFF, G_O, G_P, G_E, G_N}) begin
      n_fail++; $display("FAIL open_hex: got %h want OPEn", {h5, h4, h3, h2, h1, h0});
    end
    pulse_relock();
    n_tests++;
    if (is_open !== 1'b0) begin n_fail++; $display("FAIL relock: is_open got %b want 0", is_open); end
  endtask

  task automatic test_illegal();
    dv = 1'b1; dg = 4'hC;
    #1;
    n_tests++;
    if ({h5, h4, h3, h2, h1, h0} !== {G_OFF, G_E, G_R, G_R, G_O, G_R}) begin
      n_fail++; $display("FAIL err_hex: got %h want ErrOr", {h5, h4, h3, h2, h1, h0});
    end
    @(negedge clk);
    dv = 1'b0;
    enter(0, 32'h722297, 6, 6'b00_0000, 6'b10_0000, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a = obs.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL illegal_then_open: got %b want %b", a, e); end
    end
    pulse_relock();
  endtask

  task automatic test_lockout();
    enter(0, 32'h022297, 6, 6'b00_0000, 6'b00_0001, 1'b0);
    n_tests++;
    if ({h5, h4, h3, h2, h1, h0} !== {G_C, G_L, G_O, G_S, G_E, G_D}) begin
      n_fail++; $display("FAIL closed_hex: got %h want CLOSEd", {h5, h4, h3, h2, h1, h0});
    end
    enter(0, 32'h022297, 6, 6'b00_0001, 6'b00_0010, 1'b0);
    enter(0, 32'h022297, 6, 6'b00_0010, 6'b01_0011, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      sb.push_back((k < 16) ? 6'b01_0011 : 6'b00_0000);
      dv = (k <= 6 || k == 16);
      case (k)
        1: dg = 4'd7;  2: dg = 4'd2;  3: dg = 4'd2;
        4: dg = 4'd2;  5: dg = 4'd9;  default: dg = 4'd7;
      endcase
      #1;
      if (k == 1 || k == 16) begin
        n_tests++;
        if ({h5, h4, h3, h2, h1, h0} !== {6{G_DASH}}) begin
          n_fail++; $display("FAIL lockout_hex[%0d]: got %h want all dashes", k, {h5, h4, h3, h2, h1, h0});
        end
      end
      @(negedge clk);
      obs.push_back({is_open, locked_out, fails});
    end
    dv = 1'b0;
    enter(0, 32'h722297, 6, 6'b00_0000, 6'b10_0000, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a = obs.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL lockout_seq: got %b want %b", a, e); end
    end
    pulse_relock();
  endtask

  task automatic test_prog();
    enter(0, 32'h722297, 6, 6'b00_0000, 6'b10_0000, 1'b0);
    step(0, 1'b1, 4'd5, 1'b0);
    n_tests++;
    if (is_open !== 1'b1) begin n_fail++; $display("FAIL open_ignore: is_open got %b want 1", is_open); end
    step(0, 1'b1, 4'd1, 1'b1);
    n_tests++;
    if ({is_open, h5, h0} !== {1'b1, G_P, G_1}) begin
      n_fail++; $display("FAIL prog_enter: got %h want %h", {is_open, h5, h0}, {1'b1, G_P, G_1});
    end
    enter(0, 32'h23456, 5, 6'b10_0000, 6'b00_0000, 1'b1);
    enter(0, 32'h722297, 6, 6'b00_0000, 6'b00_0001, 1'b0);
    enter(0, 32'h123456, 6, 6'b00_0001, 6'b10_0000, 1'b0);
    pulse_reset();
    enter(0, 32'h722297, 6, 6'b00_0000, 6'b10_0000, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a = obs.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL prog_seq: got %b want %b", a, e); end
    end
    pulse_relock();
  endtask

  task automatic test_reset_mid();
    enter(0, 32'h722, 3, 6'b00_0000, 6'b00_0000, 1'b0);
    pulse_reset();
    n_tests++;
    if ({is_open, locked_out, fails, h1, h0} !== {6'b0, G_OFF, G_2}) begin
      n_fail++; $display("FAIL reset_mid: got %h want %h", {is_open, locked_out, fails, h1, h0}, {6'b0, G_OFF, G_2});
    end
    enter(0, 32'h722297, 6, 6'b00_0000, 6'b10_0000, 1'b0);
    pulse_relock();
    enter(0, 32'h111111, 6, 6'b00_0000, 6'b00_0001, 1'b0);
    enter(0, 32'h111111, 6, 6'b00_0001, 6'b00_0010, 1'b0);
    enter(0, 32'h111111, 6, 6'b00_0010, 6'b01_0011, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a = obs.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL reset_mid_seq: got %b want %b", a, e); end
    end
    pulse_reset();
    n_tests++;
    if ({is_open, locked_out, fails, h5} !== {6'b0, G_OFF}) begin
      n_fail++; $display("FAIL reset_lockout: got %h want %h", {is_open, locked_out, fails, h5}, {6'b0, G_OFF});
    end
  endtask

  task automatic test_param4();
    enter(1, 32'h1234, 4, 6'b00_0000, 6'b10_0000, 1'b0);
    b_rl = 1'b1; b_dv = 1'b1; b_dg = 4'd1;
    @(negedge clk);
    b_rl = 1'b0; b_dv = 1'b0;
    n_tests++;
    if ({b_open, b_lo, b_fails} !== 6'b0) begin
      n_fail++; $display("FAIL relock_beats_digit: got %b want 000000", {b_open, b_lo, b_fails});
    end
    enter(1, 32'h1234, 4, 6'b00_0000, 6'b10_0000, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a = obs.pop_front(); n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL digits4_seq: got %b want %b", a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_illegal();
    test_lockout();
    test_prog();
    test_reset_mid();
    test_param4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/combo_lock_param.md
Name: combo_lock_param

Overview:
- Parametrised digit-sequence combination lock, the successor to the fixed 6-digit lab lock.
- Adds configurable code length, a code reprogrammable while open, and a failed-attempt counter with timed lockout.
- Sits between the board switch/key synchroniser and six 7-segment displays; the top level maps SW/KEY onto its ports.

Parameters:
- DIGITS, 6: code length in decimal digits, legal 1..8.
- DEFAULT_CODE, 32'h00722297: reset code; the low DIGITS nibbles are used, digit 1 is the most significant used nibble.
- MAX_TRIES, 3: consecutive failed attempts that trigger lockout, legal 1..15.
- LOCKOUT_CYCLES, 16: number of clk cycles spent in LOCKOUT, legal ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- digit_valid  in  1  one-cycle strobe: digit is presented this cycle.
- digit  in  4  BCD digit from switches; 10..15 are illegal.
- prog_req  in  1  sampled with digit_valid while OPEN; requests code programming.
- relock  in  1  level; in OPEN, relocks on the next edge.
- hex0..hex5  out  7 each  active-low segments, hex0 rightmost.
- is_open  out  1  high in OPEN and PROG.
- locked_out  out  1  high in LOCKOUT.
- fails  out  4  consecutive failed attempts.

Behaviour:
- Reset (synchronous, active-high): state=ENTRY, idx=0, mismatch=0, fails=0, code=DEFAULT_CODE, lockout counter=0, is_open=0, locked_out=0. Reset has priority over all other inputs in every state, including mid-sequence, PROG and LOCKOUT. Reset also discards any programmed code.
- States (typedef lock_state_t): ENTRY, CLOSED, OPEN, PROG, LOCKOUT.
- Illegal digit (>9) with digit_valid: ignored. idx, mismatch and the stored code do not change, and no attempt is consumed.
- ENTRY, legal digit_valid:
  - mismatch |= (digit != code nibble[idx]); idx++.
  - On the DIGITS-th digit, evaluate mismatch|this_digit_mismatch:
    - match -> OPEN, fails=0.
    - fail with fails+1 == MAX_TRIES -> LOCKOUT, counter=LOCKOUT_CYCLES-1, fails=MAX_TRIES.
    - otherwise -> CLOSED, fails++.
  - idx and mismatch clear on leaving ENTRY.
- CLOSED:
  - A legal digit_valid begins a new attempt and counts as digit 1: go to ENTRY with idx=1 and mismatch taken from that digit.
  - If DIGITS==1 the attempt is evaluated in that same cycle.
- OPEN:
  - relock=1 -> ENTRY; takes priority over digit_valid.
  - digit_valid&&prog_req&&legal -> PROG; that digit is new nibble 0, idx=1.
  - digit_valid without prog_req: ignored.
- PROG:
  - Each legal digit_valid writes shadow nibble[idx]; idx++.
  - After the DIGITS-th digit: code <= shadow; go to ENTRY with idx=0.
  - relock in PROG aborts: shadow is discarded, code is unchanged, go to ENTRY.
- LOCKOUT:
  - All digit inputs are ignored; counter decrements each cycle.
  - At counter==0 -> ENTRY, fails=0. Total dwell is exactly LOCKOUT_CYCLES cycles.
- Outputs: is_open, locked_out and fails are registered. hex* are combinational from state, fails and the live digit input.
- Display by state:
  - ENTRY, CLOSED-idle and PROG, digit legal: hex0 shows digit; hex5..hex1 are OFF (7'h7F).
  - ENTRY, CLOSED-idle and PROG, digit 10..15: hex4..hex0 show "ErrOr"; hex5 is OFF.
  - In PROG only, hex5 additionally shows 'P' (7'b0001100).
  - CLOSED: "CLOSEd" across hex5..hex0, unless the digit is illegal (then Error).
  - OPEN: hex3..hex0 show "OPEn"; hex5 and hex4 are OFF.
  - LOCKOUT: all six show '-' (7'b0111111).
- Simultaneous events:
  - reset beats everything.
  - relock beats digit_valid.
  - In the final LOCKOUT cycle, digit_valid is ignored.

Decomposition:
- Package combo_lock_pkg: lock_state_t; the 7-seg constants for digits 0-9 and characters O, C, E, r, P, n, L, S, d, dash, OFF.
- Sub-module seg7_decode (4-bit BCD to active-low 7-seg) for the live digit.
- FSM, counters and code register stay in combo_lock_param.

Test Plan:
1. Default params. Reset, then enter 7,2,2,2,9,7 -> OPEN after the 6th edge; is_open=1, fails=0, hex3..hex0 = O,P,E,n.
2. In ENTRY present digit 4'hC with digit_valid -> hex4..hex0 = "ErrOr"; idx unchanged. Then 7,2,2,2,9,7 still opens.
3. Enter 0,2,2,2,9,7 three times -> CLOSED with fails=1, then fails=2, then LOCKOUT with locked_out=1. Stays 16 cycles ignoring 7,2,2,2,9,7, then ENTRY with fails=0.
4. OPEN, then prog_req with 1, followed by 2,3,4,5,6 -> ENTRY.
   - Entering 722297 -> CLOSED.
   - Entering 123456 -> OPEN.
   - Assert reset, then 722297 -> OPEN (default code restored).
5. Assert reset after 3 correct digits and while in LOCKOUT -> next cycle state=ENTRY, idx=0, outputs at reset values.
6. DIGITS=4, DEFAULT_CODE=32'h1234. Enter 1,2,3,4 -> OPEN. Assert relock and digit_valid together -> ENTRY, digit ignored.
